// File: rtl/receive.sv
// Receiving end of the counter-timed link: a watchdog armed by ld_cnt waits for the
// transmitter's valid strobe, then shifts in a DW-bit serial word MSB first.
module receive #(
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_cnt,
   input  logic          cnt,
   input  logic [CW-1:0] init,
   input  logic          invalid,
   input  logic          sin,
   output logic [DW-1:0] dout,
   output logic          outvalid,
   output logic          timeout,
   output logic          busy
);

   localparam int BW = $clog2(DW) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] shreg_q, shreg_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          outvalid_q, outvalid_d;
   logic          timeout_q, timeout_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= {CW{1'b0}};
         shreg_q    <= {DW{1'b0}};
         bit_q      <= {BW{1'b0}};
         dout_q     <= {DW{1'b0}};
         outvalid_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         bit_q      <= bit_d;
         dout_q     <= dout_d;
         outvalid_q <= outvalid_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic; ld_cnt overrides everything and aborts a frame silently
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      bit_d      = bit_q;
      dout_d     = dout_q;
      outvalid_d = 1'b0;
      timeout_d  = timeout_q;
      if (ld_cnt) begin
         cnt_d     = init;
         timeout_d = 1'b0;
         state_d   = ARMED;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            ARMED: begin
               // The strobe wins over an expiry on the same edge
               if (invalid) begin
                  state_d = SHIFT;
                  bit_d   = {BW{1'b0}};
               end else if (cnt && (cnt_q == {CW{1'b0}})) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end else if (cnt) begin
                  cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  cnt_d = cnt_q;
               end
            end
            SHIFT: begin
               shreg_d = {shreg_q[DW-2:0], sin};
               bit_d   = bit_q + {{(BW-1){1'b0}}, 1'b1};
               if (bit_q == LAST_BIT) begin
                  dout_d     = {shreg_q[DW-2:0], sin};
                  outvalid_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = SHIFT;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign dout     = dout_q;
   assign outvalid = outvalid_q;
   assign timeout  = timeout_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_receive.sv
// Randomized self-checking bench for receive; expectations come from event timing
// (enabled-edge counts, frame edge offsets) rather than from a state machine model.
module tb_receive;

   logic       clk;
   logic       rst;
   logic       ld_cnt;
   logic       cnt;
   logic [7:0] init;
   logic       invalid;
   logic       sin;
   logic [7:0] dout;
   logic       outvalid;
   logic       timeout;
   logic       busy;

   int total = 0;
   int bad   = 0;
   logic [7:0] last_word = 8'h00;

   receive #(.DW(8), .CW(8)) dut (
      .clk(clk), .rst(rst), .ld_cnt(ld_cnt), .cnt(cnt), .init(init),
      .invalid(invalid), .sin(sin), .dout(dout), .outvalid(outvalid),
      .timeout(timeout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int iv);
      init = 8'(iv); ld_cnt = 1'b1; invalid = 1'b0;
      tick();
      ld_cnt = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; ld_cnt = 1'b0; cnt = 1'b0; init = 8'h00; invalid = 1'b0; sin = 1'b0;
      #12;
      total++;
      if ({dout, outvalid, timeout, busy} !== 11'd0) begin
         bad++;
         $display("FAIL reset_state: got dout=%h ov=%b to=%b busy=%b expected all 0",
                  dout, outvalid, timeout, busy);
      end
      rst = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || outvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got busy=%b ov=%b expected 0 0", busy, outvalid);
      end
   endtask

   // Timeout fires on the (init+1)-th enabled edge after the load and then sticks
   task automatic test_timeout();
      for (int it = 0; it < 8; it++) begin
         int iv;
         int k;
         int budget;
         logic exp_to;
         iv = (it == 0) ? 5 : $urandom_range(0, 12);
         load(iv);
         total++;
         if (busy !== 1'b1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_armed: got busy=%b to=%b expected 1 0", busy, timeout);
         end
         k = 0;
         budget = 0;
         while (k < iv + 1 && budget < 300) begin
            cnt = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            sin = 1'($urandom_range(0, 1));
            tick();
            budget++;
            if (cnt) k++;
            exp_to = (k == iv + 1);
            total++;
            if (timeout !== exp_to || busy !== ~exp_to) begin
               bad++;
               $display("FAIL timeout_run: init=%0d edges=%0d got to=%b busy=%b expected to=%b busy=%b",
                        iv, k, timeout, busy, exp_to, ~exp_to);
            end
         end
         if (budget >= 300) begin
            total++; bad++;
            $display("FAIL timeout_budget: got no expiry within 300 edges expected init+1=%0d", iv + 1);
         end
         for (int s = 0; s < 4; s++) begin
            cnt = 1'($urandom_range(0, 1));
            invalid = 1'($urandom_range(0, 1));
            sin = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (timeout !== 1'b1 || busy !== 1'b0 || outvalid !== 1'b0) begin
               bad++;
               $display("FAIL timeout_sticky: got to=%b busy=%b ov=%b expected 1 0 0",
                        timeout, busy, outvalid);
            end
         end
         invalid = 1'b0;
      end
   endtask

   task automatic test_enable_hold();
      int edges;
      load(3);
      cnt = 1'b0;
      for (int s = 0; s < 4; s++) tick();
      cnt = 1'b1;
      edges = 0;
      while (timeout !== 1'b1 && edges < 20) begin
         tick();
         edges++;
      end
      total++;
      if (edges != 4) begin
         bad++;
         $display("FAIL enable_hold: got expiry after %0d counting edges expected 4", edges);
      end
   endtask

   // Frames: strobe after w-1 counting edges (w = init+1 is the expiry race)
   task automatic test_frame();
      for (int it = 0; it < 8; it++) begin
         int iv;
         int w;
         logic [7:0] data;
         if (it == 0) begin
            iv = 5; w = 3; data = 8'hA5;
         end else if (it == 1) begin
            iv = 2; w = 3; data = 8'(($urandom));
         end else begin
            iv = $urandom_range(0, 10);
            w = $urandom_range(1, iv + 1);
            data = 8'($urandom);
         end
         load(iv);
         cnt = 1'b1;
         for (int j = 1; j < w; j++) begin
            sin = 1'($urandom_range(0, 1));
            tick();
         end
         invalid = 1'b1;
         sin = 1'($urandom_range(0, 1));
         tick();
         total++;
         if (busy !== 1'b1 || timeout !== 1'b0 || outvalid !== 1'b0) begin
            bad++;
            $display("FAIL frame_start: init=%0d w=%0d got busy=%b to=%b ov=%b expected 1 0 0",
                     iv, w, busy, timeout, outvalid);
         end
         for (int b = 7; b >= 0; b--) begin
            sin = data[b];
            invalid = 1'($urandom_range(0, 1));
            cnt = 1'($urandom_range(0, 1));
            tick();
            if (b > 0) begin
               total++;
               if (busy !== 1'b1 || outvalid !== 1'b0 || dout !== last_word) begin
                  bad++;
                  $display("FAIL frame_shift: bit=%0d got busy=%b ov=%b dout=%h expected 1 0 %h",
                           b, busy, outvalid, dout, last_word);
               end
            end
         end
         total++;
         if (dout !== data || outvalid !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_done: got dout=%h ov=%b to=%b busy=%b expected %h 1 0 0",
                     dout, outvalid, timeout, busy, data);
         end
         last_word = data;
         invalid = 1'b1;
         tick();
         invalid = 1'b0;
         tick();
         total++;
         if (outvalid !== 1'b0 || dout !== data || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_after: got ov=%b dout=%h busy=%b expected 0 %h 0",
                     outvalid, dout, busy, data);
         end
      end
   endtask

   task automatic test_abort();
      int iv2;
      int edges;
      load($urandom_range(2, 9));
      cnt = 1'b1;
      invalid = 1'b1;
      tick();
      invalid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         sin = 1'($urandom_range(0, 1));
         tick();
      end
      iv2 = $urandom_range(0, 9);
      init = 8'(iv2);
      ld_cnt = 1'b1;
      tick();
      ld_cnt = 1'b0;
      total++;
      if (outvalid !== 1'b0 || dout !== last_word || busy !== 1'b1 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL abort: got ov=%b dout=%h busy=%b to=%b expected 0 %h 1 0",
                  outvalid, dout, busy, timeout, last_word);
      end
      cnt = 1'b0;
      for (int s = 0; s < 9; s++) begin
         sin = 1'($urandom_range(0, 1));
         tick();
         total++;
         if (outvalid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_armed: got ov=%b busy=%b expected 0 1", outvalid, busy);
         end
      end
      cnt = 1'b1;
      edges = 0;
      while (timeout !== 1'b1 && edges < 40) begin
         tick();
         edges++;
      end
      total++;
      if (edges != iv2 + 1 || dout !== last_word) begin
         bad++;
         $display("FAIL abort_reload: got expiry after %0d edges dout=%h expected %0d %h",
                  edges, dout, iv2 + 1, last_word);
      end
   endtask

   task automatic test_reset_mid_shift();
      load(4);
      cnt = 1'b1;
      invalid = 1'b1;
      tick();
      invalid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         sin = 1'b1;
         tick();
      end
      #3;
      rst = 1'b0;
      #1;
      total++;
      if ({dout, outvalid, timeout, busy} !== 11'd0) begin
         bad++;
         $display("FAIL reset_mid_shift: got dout=%h ov=%b to=%b busy=%b expected all 0",
                  dout, outvalid, timeout, busy);
      end
      tick();
      rst = 1'b1;
      last_word = 8'h00;
      for (int b = 0; b < 6; b++) begin
         sin = 1'b1;
         tick();
         total++;
         if (outvalid !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
            bad++;
            $display("FAIL reset_resume: got ov=%b busy=%b dout=%h expected 0 0 00",
                     outvalid, busy, dout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_enable_hold();
      test_frame();
      test_abort();
      test_reset_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
